// File: rtl/keypad_event_controller.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_event_controller
//  Purpose  : Synchronizes and debounces the keypad encoder output and emits
//             one valid/ready event per debounced key press.
//  Revision : 1.0 - initial release
// ============================================================================
module keypad_event_controller #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_press,
    input  logic [1:0] key_code,
    input  logic       ev_ready,
    input  logic       ovf_clr,
    output logic       ev_valid,
    output logic [1:0] ev_code,
    output logic       busy,
    output logic       overflow
);

    localparam logic [15:0] c_cnt_last = 16'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_DB_PRESS   = 2'd1,
        ST_HELD       = 2'd2,
        ST_DB_RELEASE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic [1:0]  r_cand;
    logic [1:0]  w_cand_nxt;
    logic        w_push;
    logic        w_pop;

    logic        r_press_meta;
    logic        r_press_sync;
    logic [1:0]  r_code_meta;
    logic [1:0]  r_code_sync;

    logic        r_ev_valid;
    logic [1:0]  r_ev_code;
    logic        r_overflow;

    // Two-flop synchronizer for the asynchronous encoder outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_press_meta <= 1'b0;
            r_press_sync <= 1'b0;
            r_code_meta  <= 2'b00;
            r_code_sync  <= 2'b00;
        end else begin
            r_press_meta <= key_press;
            r_press_sync <= r_press_meta;
            r_code_meta  <= key_code;
            r_code_sync  <= r_code_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 16'd0;
            r_cand  <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cand  <= w_cand_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cand_nxt  = r_cand;
        w_push      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_press_sync) begin
                    w_cand_nxt  = r_code_sync;
                    w_cnt_nxt   = 16'd1;
                    w_state_nxt = ST_DB_PRESS;
                end
            end
            ST_DB_PRESS: begin
                // Any code change restarts the debounce through IDLE
                if (!r_press_sync || (r_code_sync != r_cand)) begin
                    w_cnt_nxt   = 16'd0;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == c_cnt_last) begin
                    w_cnt_nxt   = 16'd0;
                    w_push      = 1'b1;
                    w_state_nxt = ST_HELD;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            ST_HELD: begin
                if (!r_press_sync) begin
                    w_cnt_nxt   = 16'd1;
                    w_state_nxt = ST_DB_RELEASE;
                end
            end
            ST_DB_RELEASE: begin
                if (r_press_sync) begin
                    w_cnt_nxt   = 16'd0;
                    w_state_nxt = ST_HELD;
                end else if (r_cnt == c_cnt_last) begin
                    w_cnt_nxt   = 16'd0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            default: begin
                w_cnt_nxt   = 16'd0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_pop = r_ev_valid & ev_ready;

    // Single-entry event buffer; a push into a full, unpopped slot is dropped
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ev_valid <= 1'b0;
            r_ev_code  <= 2'b00;
            r_overflow <= 1'b0;
        end else begin
            if (w_push && (!r_ev_valid || w_pop)) begin
                r_ev_valid <= 1'b1;
                r_ev_code  <= r_cand;
            end else if (w_pop) begin
                r_ev_valid <= 1'b0;
            end

            if (w_push && r_ev_valid && !w_pop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign ev_valid = r_ev_valid;
    assign ev_code  = r_ev_code;
    assign overflow = r_overflow;
    assign busy     = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_keypad_event_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_event_controller
//  Purpose  : Scenario-driven scoreboard bench for keypad_event_controller.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_event_controller;

    localparam int D = 4;

    logic       clk;
    logic       rst_n;
    logic       key_press;
    logic [1:0] key_code;
    logic       ev_ready;
    logic       ovf_clr;
    logic       ev_valid;
    logic [1:0] ev_code;
    logic       busy;
    logic       overflow;

    int         n_cmp;
    int         n_err;
    logic [1:0] exp_q[$];

    keypad_event_controller #(.DEBOUNCE_CYCLES(D)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_press(key_press),
        .key_code (key_code),
        .ev_ready (ev_ready),
        .ovf_clr  (ovf_clr),
        .ev_valid (ev_valid),
        .ev_code  (ev_code),
        .busy     (busy),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every handshake seen by the consumer is matched against the scoreboard
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ev_valid === 1'b1 && ev_ready === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL ev_unexpected: got code %b, expected no event", ev_code);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                if (ev_code !== e) begin
                    n_err++;
                    $display("FAIL ev_code_scoreboard: got %b, expected %b", ev_code, e);
                end
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; key_press = 1'b0; key_code = 2'b00; ev_ready = 1'b1; ovf_clr = 1'b0;
        tick(2);
        n_cmp++;
        if (ev_valid !== 1'b0) begin n_err++; $display("FAIL reset_ev_valid: got %b, expected 0", ev_valid); end
        n_cmp++;
        if (ev_code !== 2'b00) begin n_err++; $display("FAIL reset_ev_code: got %b, expected 00", ev_code); end
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        n_cmp++;
        if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b, expected 0", overflow); end
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_clean_press();
        ev_ready = 1'b1; key_code = 2'b10; key_press = 1'b1;
        tick(2);
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL clean_busy_early: got %b, expected 0", busy); end
        tick(1);
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL clean_busy_rise: got %b, expected 1", busy); end
        tick(2);
        n_cmp++;
        if (ev_valid !== 1'b0) begin n_err++; $display("FAIL clean_ev_early: got %b, expected 0", ev_valid); end
        exp_q.push_back(2'b10);
        tick(1);
        n_cmp++;
        if (ev_valid !== 1'b1 || ev_code !== 2'b10)
            begin n_err++; $display("FAIL clean_ev_rise: got v=%b c=%b, expected v=1 c=10", ev_valid, ev_code); end
        tick(1);
        n_cmp++;
        if (ev_valid !== 1'b0) begin n_err++; $display("FAIL clean_ev_pulse: got %b, expected 0", ev_valid); end
        tick(13);
        n_cmp++;
        if (ev_valid !== 1'b0 || busy !== 1'b1)
            begin n_err++; $display("FAIL clean_held: got v=%b busy=%b, expected v=0 busy=1", ev_valid, busy); end
        key_press = 1'b0;
        tick(D + 1);
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL clean_busy_release: got %b, expected 1", busy); end
        tick(1);
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL clean_busy_fall: got %b, expected 0", busy); end
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL clean_missing: got %0d pending, expected 0", exp_q.size()); end
    endtask

    task automatic test_press_bounce();
        ev_ready = 1'b1; key_code = 2'b01; key_press = 1'b1;
        tick(2);
        key_press = 1'b0;
        tick(1);
        key_press = 1'b1;
        tick(D + 1);
        n_cmp++;
        if (ev_valid !== 1'b0) begin n_err++; $display("FAIL bounce_ev_early: got %b, expected 0", ev_valid); end
        exp_q.push_back(2'b01);
        tick(1);
        n_cmp++;
        if (ev_valid !== 1'b1 || ev_code !== 2'b01)
            begin n_err++; $display("FAIL bounce_ev_rise: got v=%b c=%b, expected v=1 c=01", ev_valid, ev_code); end
        tick(9);
        key_press = 1'b0;
        tick(D + 4);
        n_cmp++;
        if (exp_q.size() != 0 || busy !== 1'b0)
            begin n_err++; $display("FAIL bounce_end: got pending=%0d busy=%b, expected 0/0", exp_q.size(), busy); end
    endtask

    task automatic test_code_change();
        ev_ready = 1'b1; key_code = 2'b01; key_press = 1'b1;
        tick(2);
        key_code = 2'b11;
        tick(D + 2);
        n_cmp++;
        if (ev_valid !== 1'b0) begin n_err++; $display("FAIL code_ev_early: got %b, expected 0", ev_valid); end
        exp_q.push_back(2'b11);
        tick(1);
        n_cmp++;
        if (ev_valid !== 1'b1 || ev_code !== 2'b11)
            begin n_err++; $display("FAIL code_ev_rise: got v=%b c=%b, expected v=1 c=11", ev_valid, ev_code); end
        tick(8);
        key_press = 1'b0;
        tick(D + 4);
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL code_missing: got %0d pending, expected 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        ev_ready = 1'b0; key_code = 2'b00; key_press = 1'b1;
        exp_q.push_back(2'b00);
        tick(D + 4);
        n_cmp++;
        if (ev_valid !== 1'b1 || ev_code !== 2'b00 || overflow !== 1'b0)
            begin n_err++; $display("FAIL bp_first: got v=%b c=%b ovf=%b, expected 1/00/0", ev_valid, ev_code, overflow); end
        key_press = 1'b0;
        tick(D + 4);
        key_code = 2'b11; key_press = 1'b1;
        for (int i = 0; i < D + 4; i++) begin
            tick(1);
            n_cmp++;
            if (ev_valid !== 1'b1 || ev_code !== 2'b00)
                begin n_err++; $display("FAIL bp_hold[%0d]: got v=%b c=%b, expected 1/00", i, ev_valid, ev_code); end
        end
        n_cmp++;
        if (overflow !== 1'b1) begin n_err++; $display("FAIL bp_overflow_set: got %b, expected 1", overflow); end
        key_press = 1'b0;
        tick(D + 4);
        ev_ready = 1'b1;
        tick(1);
        n_cmp++;
        if (ev_valid !== 1'b0 || overflow !== 1'b1)
            begin n_err++; $display("FAIL bp_pop: got v=%b ovf=%b, expected 0/1", ev_valid, overflow); end
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        n_cmp++;
        if (overflow !== 1'b0) begin n_err++; $display("FAIL bp_ovf_clr: got %b, expected 0", overflow); end
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL bp_missing: got %0d pending, expected 0", exp_q.size()); end
    endtask

    task automatic test_release_bounce();
        ev_ready = 1'b1; key_code = 2'b10; key_press = 1'b1;
        exp_q.push_back(2'b10);
        tick(D + 6);
        key_press = 1'b0;
        tick(2);
        key_press = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            n_cmp++;
            if (ev_valid !== 1'b0 || busy !== 1'b1)
                begin n_err++; $display("FAIL relb_hold[%0d]: got v=%b busy=%b, expected 0/1", i, ev_valid, busy); end
        end
        key_press = 1'b0;
        tick(D + 4);
        n_cmp++;
        if (exp_q.size() != 0 || busy !== 1'b0)
            begin n_err++; $display("FAIL relb_end: got pending=%0d busy=%b, expected 0/0", exp_q.size(), busy); end
    endtask

    task automatic test_reset_mid();
        ev_ready = 1'b0; key_code = 2'b01; key_press = 1'b1;
        exp_q.push_back(2'b01);
        tick(D + 4);
        key_press = 1'b0;
        tick(D + 4);
        key_code = 2'b10; key_press = 1'b1;
        tick(3);
        n_cmp++;
        if (busy !== 1'b1 || ev_valid !== 1'b1)
            begin n_err++; $display("FAIL rmid_pre: got busy=%b v=%b, expected 1/1", busy, ev_valid); end
        rst_n = 1'b0;
        tick(1);
        n_cmp++;
        if (ev_valid !== 1'b0 || ev_code !== 2'b00 || busy !== 1'b0 || overflow !== 1'b0)
            begin n_err++; $display("FAIL rmid_outputs: got v=%b c=%b busy=%b ovf=%b, expected all 0",
                                    ev_valid, ev_code, busy, overflow); end
        exp_q.delete();
        rst_n = 1'b1; ev_ready = 1'b1;
        tick(D + 1);
        n_cmp++;
        if (ev_valid !== 1'b0) begin n_err++; $display("FAIL rmid_ev_early: got %b, expected 0", ev_valid); end
        exp_q.push_back(2'b10);
        tick(1);
        n_cmp++;
        if (ev_valid !== 1'b1 || ev_code !== 2'b10)
            begin n_err++; $display("FAIL rmid_ev_rise: got v=%b c=%b, expected v=1 c=10", ev_valid, ev_code); end
        key_press = 1'b0;
        tick(D + 4);
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL rmid_missing: got %0d pending, expected 0", exp_q.size()); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_clean_press();
        test_press_bounce();
        test_code_change();
        test_backpressure();
        test_release_bounce();
        test_reset_mid();
        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keypad_event_controller.md
# keypad_event_controller

Sequences the raw output of the vending machine's 4-key priority encoder (`key_press`, 2-bit `key_code`) into clean, single-shot key events. It synchronizes the asynchronous button levels and debounces both press and release. It emits exactly one event per debounced press over a valid/ready handshake, so the purchase FSM downstream sees one selection per physical button push. It sits between the keypad encoder and the vending control logic.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronized samples required to accept a press or a release. Legal range 2..65535.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset; **synchronous and active-low**. This is already decided.
- `key_press`  in  1  encoder "any key pressed" level; asynchronous.
- `key_code`  in  2  encoder priority code; asynchronous; meaningful only when `key_press`=1.
- `ev_ready`  in  1  consumer accepts the event on this edge.
- `ovf_clr`  in  1  clears `overflow`.
- `ev_valid`  out  1  event pending.
- `ev_code`  out  2  code of the pending event.
- `busy`  out  1  high whenever the FSM is not in IDLE; decoded combinationally from the state register.
- `overflow`  out  1  sticky flag: an event was dropped due to backpressure.

## Operation
- **Synchronizer:** `key_press` and `key_code` each pass through 2 flops, giving `s_press` and `s_code`. Both synchronizer stages reset to 0.
- **Debounce counter:** 16-bit `cnt`. Candidate register `cand` is 2 bits.
- **States and transitions:**
  - IDLE: if `s_press`=1, latch `cand`=`s_code`, set `cnt`=1, and go to DB_PRESS.
  - DB_PRESS:
    - If `s_press`=0 or `s_code`≠`cand`, go to IDLE with `cnt`=0.
    - Else, if `cnt`=DEBOUNCE_CYCLES-1, go to HELD and push an event with code `cand`.
    - Else increment `cnt`.
  - HELD: if `s_press`=0, set `cnt`=1 and go to DB_RELEASE. Code changes while in HELD are ignored and produce no event.
  - DB_RELEASE:
    - If `s_press`=1, return to HELD. No new event.
    - Else, if `cnt`=DEBOUNCE_CYCLES-1, go to IDLE.
    - Else increment `cnt`.
- **Event push:**
  - If `ev_valid`=0, or `ev_valid`&`ev_ready`=1 on the same edge, load `ev_code`=`cand` and set `ev_valid`=1.
  - Otherwise discard the event and set `overflow`=1.
- **Pop:** on `ev_valid`&`ev_ready` with no simultaneous push, `ev_valid` goes to 0. `ev_code` keeps its last value.
- **Overflow flag:**
  - `ovf_clr`=1 clears `overflow`.
  - If a set and a clear occur on the same edge, the set wins.
- **Reset values:** state=IDLE, `cnt`=0, `cand`=0, `ev_valid`=0, `ev_code`=0, `overflow`=0, `busy`=0, synchronizer flops=0.
- **Reset mid-operation:** any pending event is lost. A key still held after reset is treated as a new press and is debounced from scratch.

## Timing
- Press latency, with E0 the first edge sampling `key_press`=1 (stable, with `ev_ready`=1):
  - `ev_valid` rises after edge E0+DEBOUNCE_CYCLES+1.
  - That is DEBOUNCE_CYCLES+2 edges in total: 2 synchronizer edges plus DEBOUNCE_CYCLES debounce samples.
- Code mismatch during DB_PRESS costs one extra cycle, because the FSM passes through IDLE before restarting.
- **Handshake:**
  - `ev_code` is stable while `ev_valid`=1.
  - `ev_valid` never drops without `ev_ready`.
  - If `ev_ready`=1 continuously, `ev_valid` is a 1-cycle pulse per event.
- Release latency before a new press can be recognized: 2 + DEBOUNCE_CYCLES edges from the first low sample.
- `busy` rises 3 edges after E0. It falls on the edge that returns the FSM to IDLE.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
1. **Clean press:** `key_code`=2'b10 and `key_press`=1 held 20 cycles, `ev_ready`=1.
   - Required: `ev_valid` pulses exactly once, for 1 cycle, after edge E0+5, with `ev_code`=2'b10.
   - Required: no further event while held.
2. **Press bounce:** `key_press` high 2 cycles, low 1, then high 15 cycles.
   - Required: exactly one event, with latency measured from the final rising edge of `key_press`.
3. **Code change during debounce:** code 2'b01 for 2 cycles, then 2'b11 held 15 cycles.
   - Required: one event with `ev_code`=2'b11.
   - Required: no event with 2'b01.
4. **Backpressure:** `ev_ready`=0; debounced press 2'b00, full release, then press 2'b11.
   - Required: `ev_valid`=1 with `ev_code`=2'b00 throughout, and `overflow`=1 after the second acceptance.
   - Then: `ev_ready`=1 for 1 cycle causes `ev_valid` to go to 0.
   - Then: `ovf_clr` pulse causes `overflow`=0.
5. **Release bounce:** key held in HELD, `key_press` low 2 cycles, then high again.
   - Required: no new event, and `busy` stays 1.
6. **Reset mid-operation:** assert `rst_n`=0 for 1 edge while in DB_PRESS with `ev_valid`=1, key still held.
   - Required: all outputs 0 after the reset edge.
   - Required: a new event after DEBOUNCE_CYCLES+2 edges from the first post-reset sample.
